// File: rtl/cpu_defs_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, IR field
// positions, sequencer state encoding and decoded instruction classes.
package cpu_defs_pkg;

  localparam int unsigned NREG = 16;
  localparam int unsigned OPW  = 5;
  localparam int unsigned REGW = 4;
  localparam int unsigned IRW  = 32;
  localparam int unsigned CLSW = 3;

  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
  localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
  localparam logic [OPW-1:0] OP_SHR  = 5'b00101;
  localparam logic [OPW-1:0] OP_SHL  = 5'b00110;
  localparam logic [OPW-1:0] OP_ROR  = 5'b00111;
  localparam logic [OPW-1:0] OP_ROL  = 5'b01000;
  localparam logic [OPW-1:0] OP_AND  = 5'b01001;
  localparam logic [OPW-1:0] OP_OR   = 5'b10001;
  localparam logic [OPW-1:0] OP_MUL  = 5'b01111;
  localparam logic [OPW-1:0] OP_DIV  = 5'b10000;
  localparam logic [OPW-1:0] OP_NOP  = 5'b11000;
  localparam logic [OPW-1:0] OP_HALT = 5'b11001;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7,
    ST_HALT = 4'd8
  } state_e;

  typedef enum logic [CLSW-1:0] {
    CLS_ALU    = 3'd0,
    CLS_MULDIV = 3'd1,
    CLS_NOP    = 3'd2,
    CLS_HALT   = 3'd3,
    CLS_ILL    = 3'd4
  } op_class_e;

  // Strobes whose value is a function of the sequencer state alone
  typedef struct packed {
    logic pc_out;
    logic zlow_out;
    logic zhigh_out;
    logic mdr_out;
    logic mar_in;
    logic z_in;
    logic pc_in;
    logic mdr_in;
    logic ir_in;
    logic hi_in;
    logic lo_in;
    logic inc_pc;
    logic read;
    logic run;
  } strobe_t;

  function automatic logic [NREG-1:0] reg_onehot(input logic [REGW-1:0] idx);
    reg_onehot = NREG'(1) << idx;
  endfunction

endpackage

// File: rtl/ir_decoder.sv
// Combinational instruction decode: opcode class plus one-hot register
// selects for the Ra/Rb/Rc fields.
module ir_decoder
  import cpu_defs_pkg::*;
(
  input  logic [IRW-1:0]  ir_i,
  output logic [CLSW-1:0] cls_o,
  output logic [NREG-1:0] ra_sel_o,
  output logic [NREG-1:0] rb_sel_o,
  output logic [NREG-1:0] rc_sel_o
);

  logic [OPW-1:0] op;
  op_class_e      cls;
  logic           unused_ir_low;

  assign op            = ir_i[OP_MSB:OP_LSB];
  assign unused_ir_low = ^ir_i[RC_LSB-1:0];

  always_comb begin
    cls = CLS_ILL;
    unique case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: cls = CLS_ALU;
      OP_MUL, OP_DIV:                cls = CLS_MULDIV;
      OP_NOP:                        cls = CLS_NOP;
      OP_HALT:                       cls = CLS_HALT;
      default:                       cls = CLS_ILL;
    endcase
  end

  assign cls_o    = CLSW'(cls);
  assign ra_sel_o = reg_onehot(ir_i[RA_MSB:RA_LSB]);
  assign rb_sel_o = reg_onehot(ir_i[RB_MSB:RB_LSB]);
  assign rc_sel_o = reg_onehot(ir_i[RC_MSB:RC_LSB]);

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit: fetch/decode/execute T-state sequencer producing
// full-cycle Datapath strobes, registered from the next state wherever IR allows.
module control_sequencer
  import cpu_defs_pkg::*;
(
  input  logic            Clock,
  input  logic            Reset,
  input  logic            Start,
  input  logic            MemReady,
  input  logic [IRW-1:0]  IR,
  output logic            PCout,
  output logic            Zlowout,
  output logic            Zhighout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            IncPC,
  output logic            Read,
  output logic [NREG-1:0] GPRin,
  output logic [NREG-1:0] GPRout,
  output logic            Run,
  output logic            Illegal
);

  state_e          state_q, state_d;
  strobe_t         strb_q, strb_d;
  logic [NREG-1:0] gpr_in_q, gpr_in_d;
  logic [NREG-1:0] gpr_out_q, gpr_out_d;
  logic            t3_q, t3_d;

  logic [CLSW-1:0] cls_raw;
  op_class_e       cls;
  logic [NREG-1:0] ra_sel, rb_sel, rc_sel;
  logic            exec;

  ir_decoder u_ir_decoder (
    .ir_i     (IR),
    .cls_o    (cls_raw),
    .ra_sel_o (ra_sel),
    .rb_sel_o (rb_sel),
    .rc_sel_o (rc_sel)
  );

  assign cls  = op_class_e'(cls_raw);
  assign exec = (cls == CLS_ALU) || (cls == CLS_MULDIV);

  // Next-state sequencing
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_HALT: if (Start) state_d = ST_T0;
      ST_T0:            state_d = ST_T1;
      ST_T1:            if (MemReady) state_d = ST_T2;
      ST_T2:            state_d = ST_T3;
      ST_T3: begin
        unique case (cls)
          CLS_ALU, CLS_MULDIV: state_d = ST_T4;
          CLS_HALT:            state_d = ST_HALT;
          default:             state_d = ST_T0;
        endcase
      end
      ST_T4:            state_d = ST_T5;
      ST_T5:            state_d = (cls == CLS_MULDIV) ? ST_T6 : ST_T0;
      ST_T6:            state_d = ST_T0;
      default:          state_d = ST_IDLE;
    endcase
  end

  // Strobes for the upcoming state; IR is stable from T3 on, so T4..T6 selects
  // can be precomputed here. T3's own IR-dependent strobes are gated below.
  always_comb begin
    strb_d    = '0;
    gpr_in_d  = '0;
    gpr_out_d = '0;
    t3_d      = 1'b0;
    unique case (state_d)
      ST_T0: begin
        strb_d.pc_out = 1'b1;
        strb_d.mar_in = 1'b1;
        strb_d.inc_pc = 1'b1;
        strb_d.z_in   = 1'b1;
      end
      ST_T1: begin
        strb_d.zlow_out = 1'b1;
        strb_d.read     = 1'b1;
        strb_d.mdr_in   = 1'b1;
        strb_d.pc_in    = (state_q != ST_T1);
      end
      ST_T2: begin
        strb_d.mdr_out = 1'b1;
        strb_d.ir_in   = 1'b1;
      end
      ST_T3: t3_d = 1'b1;
      ST_T4: begin
        gpr_out_d   = rc_sel;
        strb_d.z_in = 1'b1;
      end
      ST_T5: begin
        strb_d.zlow_out = 1'b1;
        if (cls == CLS_MULDIV) strb_d.lo_in = 1'b1;
        else                   gpr_in_d     = ra_sel;
      end
      ST_T6: begin
        strb_d.zhigh_out = 1'b1;
        strb_d.hi_in     = 1'b1;
      end
      default: ;
    endcase
    strb_d.run = (state_d != ST_IDLE) && (state_d != ST_HALT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      strb_q    <= '0;
      gpr_in_q  <= '0;
      gpr_out_q <= '0;
      t3_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb_d;
      gpr_in_q  <= gpr_in_d;
      gpr_out_q <= gpr_out_d;
      t3_q      <= t3_d;
    end
  end

  assign PCout    = strb_q.pc_out;
  assign Zlowout  = strb_q.zlow_out;
  assign Zhighout = strb_q.zhigh_out;
  assign MDRout   = strb_q.mdr_out;
  assign MARin    = strb_q.mar_in;
  assign Zin      = strb_q.z_in;
  assign PCin     = strb_q.pc_in;
  assign MDRin    = strb_q.mdr_in;
  assign IRin     = strb_q.ir_in;
  assign HIin     = strb_q.hi_in;
  assign LOin     = strb_q.lo_in;
  assign IncPC    = strb_q.inc_pc;
  assign Read     = strb_q.read;
  assign Run      = strb_q.run;
  assign GPRin    = gpr_in_q;

  // IR is first valid in T3, so its decode is gated by the registered T3 flag
  assign Yin     = t3_q & exec;
  assign Illegal = t3_q & (cls == CLS_ILL);
  assign GPRout  = (t3_q && exec) ? rb_sel : gpr_out_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: each instruction is expanded into its expected
// per-cycle strobe trace and compared cycle by cycle against the DUT.
module tb_control_sequencer;

  logic        Clock = 1'b0;
  logic        Reset, Start, MemReady;
  logic [31:0] IR;
  logic        PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin;
  logic        Yin, HIin, LOin, IncPC, Read, Run, Illegal;
  logic [15:0] GPRin, GPRout;

  typedef struct packed {
    logic pc_out, zlow, zhigh, mdr_out, mar_in, z_in, pc_in, mdr_in, ir_in;
    logic y_in, hi_in, lo_in, inc_pc, read, run, illegal;
    logic [15:0] gpr_in, gpr_out;
  } ctl_t;

  ctl_t obs;
  ctl_t trace[$];
  int   checks = 0;
  int   errors = 0;
  logic [4:0] legal_ops[12];

  control_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .MemReady(MemReady), .IR(IR),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .MARin(MARin), .Zin(Zin), .PCin(PCin), .MDRin(MDRin), .IRin(IRin),
    .Yin(Yin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC), .Read(Read),
    .GPRin(GPRin), .GPRout(GPRout), .Run(Run), .Illegal(Illegal)
  );

  always #5 Clock = ~Clock;

  assign obs = {PCout, Zlowout, Zhighout, MDRout, MARin, Zin, PCin, MDRin, IRin,
                Yin, HIin, LOin, IncPC, Read, Run, Illegal, GPRin, GPRout};

  function automatic int op_kind(input logic [4:0] op);
    // 0 ALU, 1 MUL/DIV, 2 NOP, 3 HALT, 4 illegal
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110,
      5'b00111, 5'b01000, 5'b01001, 5'b10001: return 0;
      5'b01111, 5'b10000:                     return 1;
      5'b11000:                               return 2;
      5'b11001:                               return 3;
      default:                                return 4;
    endcase
  endfunction

  // Expected cycle-by-cycle strobes from T0 of this instruction onward
  task automatic build_trace(input logic [31:0] ir, input int stall);
    ctl_t c;
    int   kind;
    int   ra, rb, rc;
    kind = op_kind(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    trace.delete();
    c = '0; c.run = 1; c.pc_out = 1; c.mar_in = 1; c.inc_pc = 1; c.z_in = 1;
    trace.push_back(c);
    for (int i = 0; i <= stall; i++) begin
      c = '0; c.run = 1; c.zlow = 1; c.read = 1; c.mdr_in = 1; c.pc_in = (i == 0);
      trace.push_back(c);
    end
    c = '0; c.run = 1; c.mdr_out = 1; c.ir_in = 1;
    trace.push_back(c);
    if (kind <= 1) begin
      c = '0; c.run = 1; c.gpr_out = 16'(1) << rb; c.y_in = 1; trace.push_back(c);
      c = '0; c.run = 1; c.gpr_out = 16'(1) << rc; c.z_in = 1; trace.push_back(c);
      c = '0; c.run = 1; c.zlow = 1;
      if (kind == 0) c.gpr_in = 16'(1) << ra;
      else           c.lo_in = 1;
      trace.push_back(c);
      if (kind == 1) begin
        c = '0; c.run = 1; c.zhigh = 1; c.hi_in = 1; trace.push_back(c);
      end
    end else begin
      c = '0; c.run = 1; c.illegal = (kind == 4); trace.push_back(c);
      if (kind == 3) trace.push_back('0);
    end
  endtask

  task automatic check(input string tag, input ctl_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered at the negedge of a T0 cycle; leaves at the negedge of the next T0
  // (or inside IDLE when abort_at cuts the instruction short with Reset).
  task automatic run_instr(input string tag, input logic [31:0] ir,
                           input int stall, input int abort_at);
    int n;
    build_trace(ir, stall);
    n  = trace.size();
    IR = ir;
    for (int k = 0; k < n; k++) begin
      check($sformatf("%s_c%0d", tag, k), trace[k]);
      if (k == abort_at) begin
        Reset = 1'b1;
        Start = 1'b1;
        @(posedge Clock); @(negedge Clock);
        check({tag, "_reset"}, '0);
        return;
      end
      if (k >= 1 && k <= stall) MemReady = 1'b0;
      else if (k == stall + 1)  MemReady = 1'b1;
      else                      MemReady = 1'($urandom_range(0, 1));
      Start = (op_kind(ir[31:27]) == 3 && k == n - 1) ? 1'b0 : 1'($urandom_range(0, 1));
      @(posedge Clock); @(negedge Clock);
    end
    if (op_kind(ir[31:27]) == 3) begin
      check({tag, "_halt_hold"}, '0);
      Start = 1'b1;
      @(posedge Clock); @(negedge Clock);
      Start = 1'b0;
    end
  endtask

  initial begin
    legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                  5'b01001, 5'b10001, 5'b01111, 5'b10000, 5'b11000, 5'b11001};
    Reset = 1'b1; Start = 1'b1; MemReady = 1'b1; IR = 32'h0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("reset_state", '0);
    Reset = 1'b0; Start = 1'b0;
    @(posedge Clock); @(negedge Clock);
    check("idle_no_start", '0);
    Start = 1'b1;
    @(posedge Clock); @(negedge Clock);

    run_instr("or_r5_r2_r4", 32'h8A920000, 0, -1);
    run_instr("mul",         32'h7A920000, 0, -1);
    run_instr("or_stall3",   32'h8A920000, 3, -1);
    run_instr("illegal",     32'hF8000000, 0, -1);
    run_instr("nop_stall1",  32'hC0000000, 1, -1);
    run_instr("halt",        32'hC8000000, 0, -1);
    run_instr("div",         32'h83C78000, 2, -1);

    // Reset in T4 with Start also high: reset wins, then a clean restart
    run_instr("abort_t4",    32'h8A920000, 0, 4);
    Reset = 1'b0; Start = 1'b1;
    @(posedge Clock); @(negedge Clock);
    run_instr("after_reset", 32'h1A920000, 0, -1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ir;
      ir = $urandom;
      if ($urandom_range(0, 3) != 0) ir[31:27] = legal_ops[$urandom_range(0, 11)];
      run_instr($sformatf("rnd%0d", n), ir, int'($urandom_range(0, 3)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
